// File: rtl/sam_pkg.sv
// Shared definitions for the SAM memory arbiter.
//   state_e : arbiter FSM state encoding (IDLE, CPU, DMA, DONE)
//   owner_e : which requester holds the current access
//   ADDR_W_DEF / DATA_W_DEF : default bus widths
//   lat_cnt_w() : counter width able to hold 0..MEM_LAT
package sam_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  function automatic int lat_cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Access-latency counter.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : access start, counter returns to 0
//   inc_i        : access cycle in progress, count up
//   last_o       : current cycle is the final access cycle (count == MEM_LAT-1)
module mem_lat_counter
  import sam_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int            CW   = lat_cnt_w(MEM_LAT);
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Only meaningful while an access is running.
  assign last_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single SAM memory port between the CPU datapath and a
// DMA requester. Each access holds mem_* constant for MEM_LAT cycles, then
// spends one DONE cycle signalling completion before returning to IDLE.
//   clk, reset                     : clock, async active-high reset
//   cpu_rd/cpu_wr/cpu_addr/wdata   : CPU level requests (rd&wr acts as write)
//   cpu_rdata, wait_               : CPU read data (registered), stall flag
//   dma_req/we/addr/wdata          : DMA request, held until dma_done
//   dma_gnt, dma_done, dma_rdata   : DMA grant, completion pulse, read data
//   mem_en/we/addr/wdata, mem_rdata: synchronous memory port
module mem_arbiter
  import sam_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              wait_,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state_q;
  owner_e owner_q;
  logic   last_dma_q;
  logic   cpu_req, start_cpu, start_dma, start, cnt_last;

  assign cpu_req = cpu_rd | cpu_wr;

  // Under contention the side not served last wins.
  always_comb begin
    start_cpu = 1'b0;
    start_dma = 1'b0;
    if (state_q == ST_IDLE) begin
      if (cpu_req && dma_req) begin
        start_cpu = last_dma_q;
        start_dma = ~last_dma_q;
      end else begin
        start_cpu = cpu_req;
        start_dma = dma_req;
      end
    end
  end

  assign start = start_cpu | start_dma;

  // mem_en is high exactly in CPU/DMA, so it doubles as the count enable.
  mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (start),
    .inc_i  (mem_en),
    .last_o (cnt_last)
  );

  // Combinational from request level and state only, never from memory data.
  assign wait_ = cpu_req & ~((state_q == ST_DONE) && (owner_q == OWN_CPU));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_CPU;
      last_dma_q <= 1'b1;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      dma_gnt    <= 1'b0;
      dma_done   <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      dma_done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= start_cpu ? ST_CPU : ST_DMA;
            owner_q   <= start_cpu ? OWN_CPU : OWN_DMA;
            mem_en    <= 1'b1;
            // A simultaneous rd+wr from the CPU resolves to a write.
            mem_we    <= start_cpu ? cpu_wr : dma_we;
            mem_addr  <= start_cpu ? cpu_addr : dma_addr;
            mem_wdata <= start_cpu ? cpu_wdata : dma_wdata;
            dma_gnt   <= start_dma;
          end
        end
        ST_CPU, ST_DMA: begin
          if (cnt_last) begin
            state_q    <= ST_DONE;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            dma_gnt    <= 1'b0;
            last_dma_q <= (state_q == ST_DMA);
            dma_done   <= (state_q == ST_DMA);
            if (!mem_we) begin
              if (state_q == ST_CPU) cpu_rdata <= mem_rdata;
              else                   dma_rdata <= mem_rdata;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          clk, reset;
  logic          cpu_rd, cpu_wr, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          wait_, dma_gnt, dma_done, mem_en, mem_we;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .wait_(wait_),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          dma;
    logic [DW-1:0] rd;
    int            cyc;
  } sb_t;

  sb_t           sb_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] cpu_rd_m = '0;
  logic [DW-1:0] dma_rd_m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_sb(output sb_t e, input string tag);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=unexpected_completion expected=none", tag);
      e.dma = 1'b0; e.rd = '0; e.cyc = -1;
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic do_cpu(input logic [AW-1:0] a, input logic rd, input logic wr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rdv);
    sb_t e;
    cpu_addr = a; cpu_wdata = wd; cpu_rd = rd; cpu_wr = wr; mem_rdata = ~rdv;
    e.dma = 1'b0; e.cyc = LAT + 1; e.rd = wr ? cpu_rd_m : rdv;
    cpu_rd_m = e.rd;
    sb_q.push_back(e);
    #1;
    chk("cpu_c0_wait", wait_, 1);
    chk("cpu_c0_en", mem_en, 0);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      mem_rdata = (c == LAT) ? rdv : ~rdv;
      chk("cpu_acc_en", mem_en, 1);
      chk("cpu_acc_addr", mem_addr, a);
      chk("cpu_acc_we", mem_we, wr);
      chk("cpu_acc_wait", wait_, 1);
      chk("cpu_acc_gnt", dma_gnt, 0);
      if (wr) chk("cpu_acc_wdata", mem_wdata, wd);
    end
    tick();
    chk("cpu_done_wait", wait_, 0);
    chk("cpu_done_en", mem_en, 0);
    pop_sb(e, "cpu_sb");
    chk("cpu_rdata", cpu_rdata, e.rd);
    chk("cpu_other_rdata", dma_rdata, dma_rd_m);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    tick();
  endtask

  task automatic do_dma(input logic [AW-1:0] a, input logic we,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rdv);
    sb_t e;
    dma_addr = a; dma_we = we; dma_wdata = wd; dma_req = 1'b1; mem_rdata = ~rdv;
    e.dma = 1'b1; e.cyc = LAT + 1; e.rd = we ? dma_rd_m : rdv;
    dma_rd_m = e.rd;
    sb_q.push_back(e);
    #1;
    chk("dma_c0_gnt", dma_gnt, 0);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      mem_rdata = (c == LAT) ? rdv : ~rdv;
      chk("dma_acc_gnt", dma_gnt, 1);
      chk("dma_acc_en", mem_en, 1);
      chk("dma_acc_addr", mem_addr, a);
      chk("dma_acc_we", mem_we, we);
      chk("dma_acc_done", dma_done, 0);
      chk("dma_acc_wait", wait_, 0);
      if (we) chk("dma_acc_wdata", mem_wdata, wd);
    end
    tick();
    chk("dma_done_pulse", dma_done, 1);
    chk("dma_done_gnt", dma_gnt, 0);
    chk("dma_done_en", mem_en, 0);
    pop_sb(e, "dma_sb");
    chk("dma_rdata", dma_rdata, e.rd);
    chk("dma_other_rdata", cpu_rdata, cpu_rd_m);
    dma_req = 1'b0;
    tick();
    chk("dma_done_clear", dma_done, 0);
  endtask

  initial begin
    sb_t e;
    int  ev;
    reset = 1'b1;
    cpu_rd = 0; cpu_wr = 0; dma_req = 0; dma_we = 0;
    cpu_addr = '0; dma_addr = '0; cpu_wdata = '0; dma_wdata = '0; mem_rdata = '0;

    // Reset state.
    tick(); tick();
    chk("rst_en", mem_en, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_gnt", dma_gnt, 0);
    chk("rst_done", dma_done, 0);
    chk("rst_wait", wait_, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    reset = 1'b0;
    tick();
    chk("idle_en", mem_en, 0);
    chk("idle_wait", wait_, 0);

    // Directed accesses.
    do_cpu(12'h123, 1'b1, 1'b0, 16'h0000, 16'hBEEF);
    do_dma(12'h040, 1'b1, 16'h0A5A, 16'h3C3C);
    do_dma(12'h041, 1'b0, 16'h0000, 16'h1234);
    do_cpu(12'h200, 1'b0, 1'b1, 16'h55AA, 16'h6666);
    do_cpu(12'h010, 1'b1, 1'b1, 16'h7777, 16'h9999);
    do_cpu(12'hFFF, 1'b1, 1'b0, 16'h0000, 16'h8001);

    // Contention from reset: CPU, DMA, CPU, DMA, each MEM_LAT+2 apart.
    reset = 1'b1; cpu_rd_m = '0; dma_rd_m = '0;
    tick();
    reset = 1'b0;
    sb_q.delete();
    for (int k = 0; k < 4; k++) begin
      e.dma = k[0]; e.rd = 16'h5555; e.cyc = (LAT + 2) * k + LAT + 1;
      sb_q.push_back(e);
    end
    cpu_addr = 12'h111; dma_addr = 12'h222; dma_we = 1'b0;
    cpu_rd = 1'b1; dma_req = 1'b1; mem_rdata = 16'h5555;
    #1;
    for (int k = 0; k <= 4 * (LAT + 2); k++) begin
      if (k > 0) tick();
      ev = (cpu_rd && !wait_) ? 1 : 0;
      if (dma_done) ev = ev + 2;
      if (ev != 0) begin
        pop_sb(e, "cont_sb");
        chk("cont_owner", {30'd0, ev[1:0]}, e.dma ? 2 : 1);
        chk("cont_cycle", k, e.cyc);
      end
      if (k == 3 * (LAT + 2) + 1) begin
        cpu_rd = 1'b0; dma_req = 1'b0;
      end
    end
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("cont_missing_cycle", 32'hFFFF_FFFF, e.cyc);
    end
    chk("cont_cpu_rdata", cpu_rdata, 16'h5555);
    chk("cont_dma_rdata", dma_rdata, 16'h5555);

    // Reset during cycle 1 of a CPU read.
    reset = 1'b1; tick(); reset = 1'b0; cpu_rd_m = '0; dma_rd_m = '0;
    tick();
    cpu_addr = 12'h123; cpu_rd = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    chk("mid_pre_en", mem_en, 1);
    reset = 1'b1;
    #1;
    chk("mid_async_en", mem_en, 0);
    chk("mid_async_addr", mem_addr, 0);
    chk("mid_cpu_rdata", cpu_rdata, 0);
    chk("mid_done", dma_done, 0);
    tick();
    chk("mid_hold_en", mem_en, 0);
    chk("mid_hold_rdata", cpu_rdata, 0);
    reset = 1'b0;
    do_cpu(12'h123, 1'b1, 1'b0, 16'h0000, 16'hCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
